// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: control-mode encodings, FSM states and the BCD MM:SS value.
// Also holds the combinational BCD +1 s / -1 s step helpers used by the value register.
package timer_pkg;

   localparam logic [1:0] MODE_STOP  = 2'b00;
   localparam logic [1:0] MODE_START = 2'b01;
   localparam logic [1:0] MODE_INC   = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SET   = 2'd1,
      RUN   = 2'd2,
      ALARM = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
   } mmss_t;

   localparam mmss_t MMSS_ZERO = '0;
   localparam mmss_t MMSS_ONE  = '{min_tens: 4'd0, min_ones: 4'd0, sec_tens: 4'd0, sec_ones: 4'd1};
   localparam mmss_t MMSS_MAX  = '{min_tens: 4'd9, min_ones: 4'd9, sec_tens: 4'd5, sec_ones: 4'd9};

   // Saturates at 99:59, so min_tens can never roll past 9.
   function automatic mmss_t mmss_inc(input mmss_t v);
      mmss_t r;
      r = v;
      if (v != MMSS_MAX) begin
         if (v.sec_ones != 4'd9) begin
            r.sec_ones = v.sec_ones + 4'd1;
         end else begin
            r.sec_ones = 4'd0;
            if (v.sec_tens != 4'd5) begin
               r.sec_tens = v.sec_tens + 4'd1;
            end else begin
               r.sec_tens = 4'd0;
               if (v.min_ones != 4'd9) begin
                  r.min_ones = v.min_ones + 4'd1;
               end else begin
                  r.min_ones = 4'd0;
                  r.min_tens = v.min_tens + 4'd1;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic mmss_t mmss_dec(input mmss_t v);
      mmss_t r;
      r = v;
      if (v != MMSS_ZERO) begin
         if (v.sec_ones != 4'd0) begin
            r.sec_ones = v.sec_ones - 4'd1;
         end else begin
            r.sec_ones = 4'd9;
            if (v.sec_tens != 4'd0) begin
               r.sec_tens = v.sec_tens - 4'd1;
            end else begin
               r.sec_tens = 4'd5;
               if (v.min_ones != 4'd0) begin
                  r.min_ones = v.min_ones - 4'd1;
               end else begin
                  r.min_ones = 4'd9;
                  r.min_tens = v.min_tens - 4'd1;
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Registered BCD MM:SS value with clear/inc/dec strobes (clr > inc > dec); updates one cycle after the strobe.
// No backpressure: a strobe is always accepted; inc holds at 99:59 and dec holds at 00:00.
module bcd_mmss_counter
   import timer_pkg::*;
(
   input  logic  clk_i,
   input  logic  reset_i,
   input  logic  clr_i,
   input  logic  inc_i,
   input  logic  dec_i,
   output mmss_t value_o,
   output logic  is_zero_o,
   output logic  next_is_zero_o
);

   mmss_t value_q;
   mmss_t value_d;

   always_comb begin
      value_d = value_q;
      if (clr_i) begin
         value_d = MMSS_ZERO;
      end else if (inc_i) begin
         value_d = mmss_inc(value_q);
      end else if (dec_i) begin
         value_d = mmss_dec(value_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         value_q <= MMSS_ZERO;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o        = value_q;
   assign is_zero_o      = (value_q == MMSS_ZERO);
   // High when the next decrement would land on 00:00.
   assign next_is_zero_o = (value_q == MMSS_ONE);

endmodule

// File: rtl/countdown_seq.sv
// Countdown timer sequencer: mode-driven FSM, 1 s prescaler, INC auto-repeat and expiry alarm over a BCD MM:SS value.
// All outputs registered (one cycle after the deciding edge); no backpressure, mode is sampled every cycle.
module countdown_seq
   import timer_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int REPEAT_DIV = 12_500_000,
   parameter int ALARM_SECS = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic       clear,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int RW = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DIV - 1);
   localparam logic [3:0]    ALARM_LOAD = 4'(ALARM_SECS);

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [RW-1:0]   rep_q, rep_d;
   logic [3:0]      acnt_q, acnt_d;
   logic            running_q, running_d;
   logic            done_q, done_d;
   logic            alarm_q, alarm_d;

   logic            tick;
   logic            cnt_clr, cnt_inc, cnt_dec;
   logic            is_zero, next_is_zero;
   mmss_t           value;

   assign tick = (presc_q == PRESC_LAST);

   bcd_mmss_counter u_value (
      .clk_i          (clk),
      .reset_i        (reset),
      .clr_i          (cnt_clr),
      .inc_i          (cnt_inc),
      .dec_i          (cnt_dec),
      .value_o        (value),
      .is_zero_o      (is_zero),
      .next_is_zero_o (next_is_zero)
   );

   always_comb begin
      state_d = state_q;
      acnt_d  = acnt_q;
      alarm_d = alarm_q;
      done_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      cnt_dec = 1'b0;

      if (clear) begin
         state_d = IDLE;
         cnt_clr = 1'b1;
         alarm_d = 1'b0;
         acnt_d  = 4'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (mode == MODE_INC) begin
                  state_d = SET;
               end else if (mode == MODE_START && !is_zero) begin
                  state_d = RUN;
               end
            end
            SET: begin
               if (mode == MODE_INC) begin
                  if (rep_q == REP_LAST) cnt_inc = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (mode == MODE_INC) begin
                  state_d = SET;
               end else if (mode == MODE_START) begin
                  if (tick) begin
                     cnt_dec = 1'b1;
                     if (next_is_zero) begin
                        done_d  = 1'b1;
                        state_d = ALARM;
                        alarm_d = 1'b1;
                        acnt_d  = ALARM_LOAD;
                     end
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            ALARM: begin
               if (mode == MODE_START) begin
                  // Stay parked at 00:00; alarm just times out.
                  if (tick && acnt_q != 4'd0) begin
                     acnt_d  = acnt_q - 4'd1;
                     alarm_d = (acnt_q != 4'd1);
                  end
               end else begin
                  state_d = (mode == MODE_INC) ? SET : IDLE;
                  alarm_d = 1'b0;
                  acnt_d  = 4'd0;
               end
            end
         endcase
      end

      // Entering SET bumps the value immediately; repeats follow every REPEAT_DIV cycles.
      if (state_d == SET && state_q != SET) cnt_inc = 1'b1;

      if (state_d != state_q) begin
         presc_d = '0;
      end else if (state_q == RUN || state_q == ALARM) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end else begin
         presc_d = '0;
      end

      if (state_d != state_q) begin
         rep_d = '0;
      end else if (state_q == SET) begin
         rep_d = (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
      end else begin
         rep_d = '0;
      end

      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         rep_q     <= '0;
         acnt_q    <= 4'd0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         rep_q     <= rep_d;
         acnt_q    <= acnt_d;
         running_q <= running_d;
         done_q    <= done_d;
         alarm_q   <= alarm_d;
      end
   end

   assign min_tens = value.min_tens;
   assign min_ones = value.min_ones;
   assign sec_tens = value.sec_tens;
   assign sec_ones = value.sec_ones;
   assign running  = running_q;
   assign done     = done_q;
   assign alarm    = alarm_q;

endmodule
